// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the integer -> binary32 conversion pipeline:
//   - rounding-mode enum (encoding matches the 2-bit in_rm field)
//   - binary32 field constants
//   - per-stage control payload carried alongside the datapath
//   - rounding-increment helper used by the final stage
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int FP_BIAS  = 127;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    typedef enum logic [1:0] {
        RNE = 2'b00,    // round to nearest, ties to even
        RTZ = 2'b01,    // round toward zero
        RDN = 2'b10,    // round toward -infinity
        RUP = 2'b11     // round toward +infinity
    } rm_e;

    // Control fields that travel with every operation through all stages.
    // The width-dependent parts (magnitude, fraction, tag) are carried
    // beside this struct because they depend on module parameters.
    typedef struct packed {
        logic sign;
        rm_e  rm;
        logic zero;
    } stage_ctl_t;

    // Increment decision for the truncated mantissa.
    function automatic logic round_inc(
        input rm_e  rm,
        input logic sign,
        input logic lsb,
        input logic guard,
        input logic round,
        input logic sticky
    );
        logic inc;
        unique case (rm)
            RNE:     inc = guard && (round || sticky || lsb);
            RTZ:     inc = 1'b0;
            RDN:     inc = sign && (guard || round || sticky);
            RUP:     inc = !sign && (guard || round || sticky);
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/conv_pipe_if.sv
// ---------------------------------------------------------------------------
// conv_pipe_if
// Valid/ready bundle for conv_pipe: an input channel carrying the integer
// operation and an output channel returning the binary32 result.
//   slave  : the conversion block (consumes in_*, produces out_*)
//   master : the environment (produces in_*, consumes out_*)
// ---------------------------------------------------------------------------
interface conv_pipe_if #(
    parameter int INT_W = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [INT_W-1:0] in_int;
    logic             in_unsigned;
    logic [1:0]       in_rm;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_f;
    logic             out_inexact;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_int, in_unsigned, in_rm, in_tag, out_ready,
        output in_ready, out_valid, out_f, out_inexact, out_tag
    );

    modport master (
        output in_valid, in_int, in_unsigned, in_rm, in_tag, out_ready,
        input  in_ready, out_valid, out_f, out_inexact, out_tag
    );
endinterface

// File: rtl/conv_lzc.sv
// ---------------------------------------------------------------------------
// conv_lzc
// Combinational leading-zero counter.
//   data_i : word to scan
//   cnt_o  : number of zeros above the most significant one (0 when all-zero)
//   zero_o : data_i is all zeros
// ---------------------------------------------------------------------------
module conv_lzc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    // Scan upward so the highest set bit is the last assignment to win.
    always_comb begin
        cnt_o  = '0;
        zero_o = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                cnt_o  = CNT_W'(WIDTH - 1 - i);
                zero_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/conv_pipe.sv
// ---------------------------------------------------------------------------
// conv_pipe
// Three-stage pipelined signed/unsigned integer to IEEE-754 binary32
// converter with per-operation rounding mode and an opaque tag.
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset, clears every stage
//   bus  : conv_pipe_if.slave (in_* operation channel, out_* result channel)
// Stages: S1 sign/magnitude/zero, S2 leading-zero count + normalise,
//         S3 round + pack (S3 registers drive the outputs directly).
// Legal INT_W values are 32 and 64.
// ---------------------------------------------------------------------------
import conv_pkg::*;

module conv_pipe #(
    parameter int INT_W = 32,
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    conv_pipe_if.slave  bus
);

    localparam int LZC_W  = $clog2(INT_W);
    localparam int FRAC_W = INT_W - 1;   // bits below the leading one

    // ------------------------------------------------------------------
    // Flow control: a stage may load when it is empty or its content is
    // leaving in this same cycle. None of this looks at in_valid.
    // ------------------------------------------------------------------
    logic s1_valid_q, s2_valid_q, s3_valid_q;
    logic s1_free, s2_free, s3_free;

    assign s3_free      = !s3_valid_q || bus.out_ready;
    assign s2_free      = !s2_valid_q || s3_free;
    assign s1_free      = !s1_valid_q || s2_free;
    assign bus.in_ready = s1_free;

    // ------------------------------------------------------------------
    // S1: sign extraction, magnitude, zero detect
    // ------------------------------------------------------------------
    stage_ctl_t       s1_ctl_d, s1_ctl_q;
    logic [INT_W-1:0] s1_mag_d, s1_mag_q;
    logic [TAG_W-1:0] s1_tag_q;

    always_comb begin
        s1_ctl_d.sign = !bus.in_unsigned && bus.in_int[INT_W-1];
        s1_ctl_d.rm   = rm_e'(bus.in_rm);
        s1_ctl_d.zero = (bus.in_int == '0);
        // Full INT_W width: the most negative value maps to 2^(INT_W-1),
        // which is still representable as an unsigned magnitude.
        s1_mag_d      = s1_ctl_d.sign ? (~bus.in_int + INT_W'(1)) : bus.in_int;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_ctl_q   <= '0;
            s1_mag_q   <= '0;
            s1_tag_q   <= '0;
        end else if (s1_free) begin
            s1_valid_q <= bus.in_valid;
            s1_ctl_q   <= s1_ctl_d;
            s1_mag_q   <= s1_mag_d;
            s1_tag_q   <= bus.in_tag;
        end
    end

    // ------------------------------------------------------------------
    // S2: leading-zero count and left normalisation
    // ------------------------------------------------------------------
    logic [LZC_W-1:0]    s1_lzc;
    logic                s1_lzc_zero;
    logic [FRAC_W-1:0]   s2_frac_d, s2_frac_q;
    logic [FP_EXP_W-1:0] s2_exp_d, s2_exp_q;
    stage_ctl_t          s2_ctl_q;
    logic [TAG_W-1:0]    s2_tag_q;

    conv_lzc #(
        .WIDTH (INT_W),
        .CNT_W (LZC_W)
    ) u_lzc (
        .data_i (s1_mag_q),
        .cnt_o  (s1_lzc),
        .zero_o (s1_lzc_zero)
    );

    always_comb begin
        // Shifting only the bits below the MSB drops the leading one off the
        // top, leaving the fraction left-aligned in FRAC_W bits.
        s2_frac_d = s1_mag_q[FRAC_W-1:0] << s1_lzc;
        s2_exp_d  = s1_lzc_zero ? '0
                  : FP_EXP_W'(FP_BIAS + INT_W - 1) - FP_EXP_W'(s1_lzc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_ctl_q   <= '0;
            s2_frac_q  <= '0;
            s2_exp_q   <= '0;
            s2_tag_q   <= '0;
        end else if (s2_free) begin
            s2_valid_q <= s1_valid_q;
            s2_ctl_q   <= s1_ctl_q;
            s2_frac_q  <= s2_frac_d;
            s2_exp_q   <= s2_exp_d;
            s2_tag_q   <= s1_tag_q;
        end
    end

    // ------------------------------------------------------------------
    // S3: rounding and packing
    // ------------------------------------------------------------------
    logic [FP_MAN_W-1:0] s3_man;
    logic                s3_guard, s3_round, s3_sticky, s3_inc;
    logic [FP_MAN_W:0]   s3_man_rnd;
    logic [FP_EXP_W-1:0] s3_exp_rnd;
    logic [31:0]         s3_f_d, s3_f_q;
    logic                s3_inexact_d, s3_inexact_q;
    logic [TAG_W-1:0]    s3_tag_q;

    always_comb begin
        s3_man    = s2_frac_q[FRAC_W-1 -: FP_MAN_W];
        s3_guard  = s2_frac_q[FRAC_W-1-FP_MAN_W];
        s3_round  = s2_frac_q[FRAC_W-2-FP_MAN_W];
        s3_sticky = |s2_frac_q[FRAC_W-3-FP_MAN_W:0];
        s3_inc    = round_inc(s2_ctl_q.rm, s2_ctl_q.sign, s3_man[0],
                              s3_guard, s3_round, s3_sticky);
        // Extra top bit catches the carry-out; the low bits are then all
        // zero, so only the exponent needs adjusting.
        s3_man_rnd   = {1'b0, s3_man} + (FP_MAN_W+1)'(s3_inc);
        s3_exp_rnd   = s2_exp_q + FP_EXP_W'(s3_man_rnd[FP_MAN_W]);
        s3_inexact_d = s3_guard || s3_round || s3_sticky;
        s3_f_d       = s2_ctl_q.zero ? 32'h0000_0000
                     : {s2_ctl_q.sign, s3_exp_rnd, s3_man_rnd[FP_MAN_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid_q   <= 1'b0;
            s3_f_q       <= '0;
            s3_inexact_q <= 1'b0;
            s3_tag_q     <= '0;
        end else if (s3_free) begin
            s3_valid_q   <= s2_valid_q;
            s3_f_q       <= s3_f_d;
            s3_inexact_q <= s3_inexact_d;
            s3_tag_q     <= s2_tag_q;
        end
    end

    assign bus.out_valid   = s3_valid_q;
    assign bus.out_f       = s3_f_q;
    assign bus.out_inexact = s3_inexact_q;
    assign bus.out_tag     = s3_tag_q;

endmodule

// File: doc/conv_pipe.md
CONV_PIPE -- requirements
Module: conv_pipe

Interface
REQ-001 Parameter INT_W, default 32, meaning source integer width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 4, meaning width of the opaque tag carried alongside each operation.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  source presents an operation.
REQ-006 in_ready  output  1  block accepts the operation this cycle.
REQ-007 in_int  input  INT_W  integer operand.
REQ-008 in_unsigned  input  1  1: treat in_int as unsigned; 0: treat it as two's complement.
REQ-009 in_rm  input  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN, 11 RUP.
REQ-010 in_tag  input  TAG_W  tag, returned unchanged with the result.
REQ-011 out_valid  output  1  result is present.
REQ-012 out_ready  input  1  sink accepts the result.
REQ-013 out_f  output  32  IEEE-754 binary32 result.
REQ-014 out_inexact  output  1  result differs from the exact value.
REQ-015 out_tag  output  TAG_W  tag of the result.

Function
REQ-016 An operation SHALL transfer into the block when in_valid and in_ready are both 1, and out of the block when out_valid and out_ready are both 1.
REQ-017 The pipeline SHALL have three registered stages:
- S1: sign extraction, magnitude, zero detect.
- S2: leading-zero count and left normalisation.
- S3: rounding and packing.
REQ-018 With no backpressure, latency SHALL be exactly 3 cycles from the input handshake to out_valid=1, and throughput SHALL be 1 operation per cycle.
REQ-019 Each stage SHALL hold a valid bit and SHALL advance when the next stage is empty or is advancing in the same cycle.
- in_ready = !S1.valid || S1 advancing.
- in_ready SHALL NOT depend combinationally on in_valid.
REQ-020 While out_valid=1 and out_ready=0, out_f, out_inexact and out_tag SHALL hold stable and no operation SHALL be lost or reordered.
REQ-021 The three stages together SHALL hold at most 3 operations; in_ready SHALL be 0 when all three stages are full and out_ready=0.
REQ-022 Sign handling:
- Signed mode: sign = MSB of in_int; magnitude = two's-complement absolute value, held INT_W bits wide so that the most negative value is handled correctly.
- Unsigned mode: sign = 0.
REQ-023 A zero input SHALL produce 0x00000000 with out_inexact=0 in every rounding mode.
REQ-024 Exponent SHALL equal 127 + (INT_W-1-lzc), where lzc is the leading-zero count of the magnitude.
REQ-025 Mantissa SHALL be the 23 bits below the leading one; guard and round bits SHALL be the next two bits, and sticky SHALL be the OR of all bits below them.
REQ-026 Rounding increment SHALL be:
- RNE: guard && (round || sticky || lsb).
- RTZ: 0.
- RDN: sign && (guard || round || sticky).
- RUP: !sign && (guard || round || sticky).
REQ-027 A mantissa carry-out from rounding SHALL zero the mantissa and increment the exponent by 1.
REQ-028 out_inexact SHALL equal guard || round || sticky.
REQ-029 Overflow is impossible for INT_W ≤ 64, so no overflow or infinity path SHALL exist.
REQ-030 in_unsigned, in_rm and in_tag SHALL be sampled per operation and SHALL travel with it through every stage.

Reset
REQ-031 While rst=1 at a rising edge, all stage valid bits SHALL clear, so out_valid=0 and in_ready=1 on the next cycle.
REQ-032 out_f, out_inexact and out_tag SHALL reset to 0.
REQ-033 Operations in flight when rst is asserted mid-operation SHALL be discarded, and no result for them SHALL appear after reset.
REQ-034 An input handshake in the same cycle as rst=1 SHALL be ignored.

Structure
REQ-035 Package conv_pkg SHALL hold:
- the rounding-mode enum (RNE, RTZ, RDN, RUP);
- FP32 constants: bias 127, exponent width 8, mantissa width 23;
- the per-stage payload struct.
REQ-036 The leading-zero count SHALL be a parametrised sub-module, conv_lzc (width INT_W, output $clog2(INT_W) bits plus an all-zero flag).

Verification
REQ-037 INT_W=32, signed, RNE: input 1 -> 0x3F800000 exact; input -1 -> 0xBF800000 exact; input 0x80000000 -> 0xCF000000 exact.
REQ-038 INT_W=32, signed, input 0x7FFFFFFF:
- RNE -> 0x4F000000, inexact=1.
- RTZ -> 0x4EFFFFFF, inexact=1.
- RDN -> 0x4EFFFFFF.
- RUP -> 0x4F000000.
REQ-039 INT_W=32, input 0x01000001: RNE -> 0x4B800000, inexact=1 (tie to even); RUP -> 0x4B800001.
REQ-040 INT_W=32, unsigned, input 0xFFFFFFFF, RNE -> 0x4F800000 (rounding carry into the exponent); INT_W=64, unsigned, all-ones, RNE -> 0x5F800000.
REQ-041 Backpressure: hold out_ready=0 and send 5 back-to-back operations with tags 0-4 -> in_ready falls after 3 accepts; release out_ready -> results return in tag order 0-4, none dropped or duplicated, each held stable while stalled.
REQ-042 Reset mid-stream: assert rst for 1 cycle with 3 operations in flight -> out_valid=0 and in_ready=1 on the next cycle, and none of the 3 results appear afterward.
